// File: rtl/dot_accumulator.sv
// Dot-product accumulator behind a pipelined multiplier, with a credit-protected result FIFO.
// Optional saturation and sticky overflow flag when ACC_SAT_EN is defined.
module dot_accumulator #(
  parameter int unsigned PROD_W     = 16,
  parameter int unsigned ACC_W      = 24,
  parameter int unsigned MULT_LAT   = 5,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [PROD_W-1:0] product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_sat
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + MULT_LAT + 1);

  typedef enum logic {StIdle, StAcc} state_t;

  logic [MULT_LAT-1:0] r_dl_v;
  logic [MULT_LAT-1:0] r_dl_l;
  logic [CNT_W-1:0]    r_inflight;
  logic [CNT_W-1:0]    r_count;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [ACC_W-1:0]    r_mem [FIFO_DEPTH];
  logic [ACC_W-1:0]    r_acc;
  state_t              r_state;

  logic                w_accept;
  logic                w_d_v;
  logic                w_d_l;
  logic [CNT_W:0]      w_credit_used;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic [ACC_W-1:0]    w_push_data;
  logic [ACC_W-1:0]    w_sum;
  logic [ACC_W-1:0]    w_acc_d;
  state_t              w_state_d;

  assign w_accept = in_valid && in_ready;
  assign w_d_v    = r_dl_v[MULT_LAT-1];
  assign w_d_l    = r_dl_l[MULT_LAT-1];

  // Credits count both queued results and last-terms still travelling the multiplier.
  assign w_credit_used = (CNT_W+1)'(r_count) + (CNT_W+1)'(r_inflight);
  assign in_ready      = w_credit_used < (CNT_W+1)'(FIFO_DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dl_v     <= '0;
      r_dl_l     <= '0;
      r_inflight <= '0;
    end else begin
      for (int i = MULT_LAT - 1; i > 0; i--) begin
        r_dl_v[i] <= r_dl_v[i-1];
        r_dl_l[i] <= r_dl_l[i-1];
      end
      r_dl_v[0]  <= w_accept;
      r_dl_l[0]  <= in_last;
      r_inflight <= r_inflight + CNT_W'(w_accept && in_last) - CNT_W'(w_d_v && w_d_l);
    end
  end

`ifdef ACC_SAT_EN
  logic [ACC_W:0] w_sum_full;
  logic           w_clamp;
  logic           w_push_sat;
  logic           r_flag;
  logic           r_sat_mem [FIFO_DEPTH];

  assign w_sum_full = {1'b0, r_acc} + (ACC_W+1)'(product);
  assign w_clamp    = w_sum_full[ACC_W];
  assign w_sum      = w_clamp ? '1 : w_sum_full[ACC_W-1:0];
  // A single-term result from IDLE can never overflow, so only ACC pushes carry the flag.
  assign w_push_sat = (r_state == StAcc) && (r_flag || w_clamp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flag <= 1'b0;
    end else if (w_d_v) begin
      r_flag <= (r_state == StAcc) && !w_d_l && (r_flag || w_clamp);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_sat_mem[r_wr_ptr] <= w_push_sat;
    end
  end

  assign out_sat = out_valid && r_sat_mem[r_rd_ptr];
`else
  assign w_sum   = r_acc + ACC_W'(product);
  assign out_sat = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_d;
      r_acc   <= w_acc_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_acc_d     = r_acc;
    w_push      = 1'b0;
    w_push_data = '0;
    unique case (r_state)
      StIdle: begin
        if (w_d_v && w_d_l) begin
          w_push      = 1'b1;
          w_push_data = ACC_W'(product);
        end else if (w_d_v) begin
          w_acc_d   = ACC_W'(product);
          w_state_d = StAcc;
        end
      end
      StAcc: begin
        if (w_d_v && w_d_l) begin
          w_push      = 1'b1;
          w_push_data = w_sum;
          w_acc_d     = '0;
          w_state_d   = StIdle;
        end else if (w_d_v) begin
          w_acc_d = w_sum;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign w_pop  = out_valid && out_ready;
  assign w_full = r_count == CNT_W'(FIFO_DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  assign out_valid = r_count != '0;
  assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(w_push && w_full));

endmodule

// File: tb/tb_dot_accumulator.sv
// Directed bench for dot_accumulator with a behavioural pipelined multiplier in front.
module tb_dot_accumulator;

  localparam int unsigned LAT = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [15:0] mul_pipe [LAT];
  logic [15:0] product;

  logic        in_valid = 1'b0, in_last = 1'b0, in_ready;
  logic        out_valid, out_ready = 1'b0, out_sat;
  logic [23:0] out_data;

  logic        in_valid17 = 1'b0, in_last17 = 1'b0, in_ready17;
  logic        out_valid17, out_ready17 = 1'b0, out_sat17;
  logic [16:0] out_data17;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;

  logic [31:0] q_data [$];
  bit          q_sat [$];
  int unsigned q_cyc [$];
  logic [31:0] q17_data [$];
  bit          q17_sat [$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mul_pipe[0] <= {8'd0, a} * {8'd0, b};
    for (int i = 1; i < LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
    cyc <= cyc + 1;
  end
  assign product = mul_pipe[LAT-1];

  dot_accumulator #(.PROD_W(16), .ACC_W(24), .MULT_LAT(LAT), .FIFO_DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .product   (product),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  dot_accumulator #(.PROD_W(16), .ACC_W(17), .MULT_LAT(LAT), .FIFO_DEPTH(2)) dut17 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid17),
    .in_last   (in_last17),
    .in_ready  (in_ready17),
    .product   (product),
    .out_valid (out_valid17),
    .out_ready (out_ready17),
    .out_data  (out_data17),
    .out_sat   (out_sat17)
  );

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      q_data.push_back(32'(out_data));
      q_sat.push_back(out_sat);
      q_cyc.push_back(cyc);
    end
    if (!rst && out_valid17 && out_ready17) begin
      q17_data.push_back(32'(out_data17));
      q17_sat.push_back(out_sat17);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] qd(input int i);
    return (i < q_data.size()) ? q_data[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic clear_queues();
    q_data.delete();
    q_sat.delete();
    q_cyc.delete();
    q17_data.delete();
    q17_sat.delete();
  endtask

  // Holds a term until accepted; called just after a rising edge.
  task automatic send(input bit sel, input logic [7:0] ta, input logic [7:0] tb, input bit last);
    bit done;
    done = 1'b0;
    a = ta;
    b = tb;
    if (sel) begin
      in_valid17 = 1'b1;
      in_last17  = last;
    end else begin
      in_valid = 1'b1;
      in_last  = last;
    end
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if ((sel ? in_ready17 : in_ready) == 1'b1) begin
        done    = 1'b1;
        acc_cyc = cyc;
      end
      @(posedge clk);
      #1;
    end
    in_valid   = 1'b0;
    in_last    = 1'b0;
    in_valid17 = 1'b0;
    in_last17  = 1'b0;
    check_eq("accept", 32'(done), 32'd1);
  endtask

  initial begin
    int unsigned t_acc;

    rst = 1'b1;
    wait_cycles(3);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_out_sat", 32'(out_sat), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    wait_cycles(2);

    // single term: latency and one-cycle pulse
    out_ready = 1'b1;
    clear_queues();
    send(1'b0, 8'd13, 8'd7, 1'b1);
    t_acc = acc_cyc;
    wait_cycles(12);
    check_eq("t1_count", 32'(q_data.size()), 32'd1);
    check_eq("t1_data", qd(0), 32'd91);
    check_eq("t1_latency", (q_cyc.size() > 0) ? q_cyc[0] - t_acc : 32'hFFFF, 32'(LAT + 1));

    // four terms back-to-back
    clear_queues();
    send(1'b0, 8'd13, 8'd7, 1'b0);
    send(1'b0, 8'd255, 8'd255, 1'b0);
    send(1'b0, 8'd0, 8'd123, 1'b0);
    send(1'b0, 8'd128, 8'd2, 1'b1);
    wait_cycles(12);
    check_eq("t2_count", 32'(q_data.size()), 32'd1);
    check_eq("t2_data", qd(0), 32'd65372);
    check_eq("t2_sat", (q_sat.size() > 0) ? 32'(q_sat[0]) : 32'd9, 32'd0);

    // same terms with bubbles
    clear_queues();
    send(1'b0, 8'd13, 8'd7, 1'b0);
    wait_cycles(2);
    send(1'b0, 8'd255, 8'd255, 1'b0);
    wait_cycles(2);
    send(1'b0, 8'd0, 8'd123, 1'b0);
    wait_cycles(2);
    send(1'b0, 8'd128, 8'd2, 1'b1);
    wait_cycles(14);
    check_eq("t3_count", 32'(q_data.size()), 32'd1);
    check_eq("t3_data", qd(0), 32'd65372);

    // backpressure: credits stop the source, head is held
    clear_queues();
    out_ready = 1'b0;
    send(1'b0, 8'd1, 8'd1, 1'b1);
    send(1'b0, 8'd2, 8'd2, 1'b1);
    @(negedge clk);
    check_eq("t4_in_ready_low", 32'(in_ready), 32'd0);
    wait_cycles(8);
    @(negedge clk);
    check_eq("t4_out_valid", 32'(out_valid), 32'd1);
    check_eq("t4_hold_a", 32'(out_data), 32'd1);
    wait_cycles(3);
    @(negedge clk);
    check_eq("t4_hold_b", 32'(out_data), 32'd1);
    check_eq("t4_in_ready_still_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(1'b0, 8'd3, 8'd3, 1'b1);
    wait_cycles(12);
    check_eq("t4_count", 32'(q_data.size()), 32'd3);
    check_eq("t4_r0", qd(0), 32'd1);
    check_eq("t4_r1", qd(1), 32'd4);
    check_eq("t4_r2", qd(2), 32'd9);

    // reset mid dot product discards the partial sum
    clear_queues();
    send(1'b0, 8'd5, 8'd5, 1'b0);
    send(1'b0, 8'd6, 8'd6, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t5_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("t5_rst_in_ready", 32'(in_ready), 32'd1);
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(8);
    check_eq("t5_quiet", 32'(out_valid), 32'd0);
    send(1'b0, 8'd2, 8'd3, 1'b1);
    wait_cycles(12);
    check_eq("t5_count", 32'(q_data.size()), 32'd1);
    check_eq("t5_data", qd(0), 32'd6);

    // 17-bit accumulator overflow
    clear_queues();
    out_ready17 = 1'b1;
    send(1'b1, 8'd255, 8'd255, 1'b0);
    send(1'b1, 8'd255, 8'd255, 1'b0);
    send(1'b1, 8'd255, 8'd255, 1'b1);
    wait_cycles(12);
    check_eq("t6_count", 32'(q17_data.size()), 32'd1);
`ifdef ACC_SAT_EN
    check_eq("t6_data", (q17_data.size() > 0) ? q17_data[0] : 32'hDEAD_BEEF, 32'd131071);
    check_eq("t6_sat", (q17_sat.size() > 0) ? 32'(q17_sat[0]) : 32'd9, 32'd1);
`else
    check_eq("t6_data", (q17_data.size() > 0) ? q17_data[0] : 32'hDEAD_BEEF, 32'd64003);
    check_eq("t6_sat", (q17_sat.size() > 0) ? 32'(q17_sat[0]) : 32'd9, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
